// File: rtl/apb_timer_slave_pkg.sv
// Register map, bit positions and shared types for the APB timer slave.
// Imported by the timer counter, the APB completer top and the bench.
package apb_timer_slave_pkg;

    localparam int TDR_ADDR  = 0;
    localparam int TCR_ADDR  = 1;
    localparam int TSR_ADDR  = 2;
    localparam int TCNT_ADDR = 3;

    localparam int TCR_LOAD_BIT   = 7;
    localparam int TCR_UPDOWN_BIT = 5;
    localparam int TCR_EN_BIT     = 4;
    localparam int TCR_CKS_MSB    = 1;
    localparam int TCR_CKS_LSB    = 0;

    localparam int TSR_OVF_BIT = 0;
    localparam int TSR_UDF_BIT = 1;

    typedef enum logic [1:0] {
        APB_IDLE,
        APB_SETUP,
        APB_ACCESS
    } apb_state_e;

    // Only the implemented TCR bits are stored; the rest read back as 0.
    typedef struct packed {
        logic       load;
        logic       updown;
        logic       en;
        logic [1:0] cks;
    } tcr_t;

    function automatic logic [7:0] tcr_to_byte(input tcr_t t);
        logic [7:0] b;
        b                            = '0;
        b[TCR_LOAD_BIT]              = t.load;
        b[TCR_UPDOWN_BIT]            = t.updown;
        b[TCR_EN_BIT]                = t.en;
        b[TCR_CKS_MSB:TCR_CKS_LSB]   = t.cks;
        return b;
    endfunction

    function automatic tcr_t tcr_from_byte(input logic [7:0] b);
        tcr_t t;
        t.load   = b[TCR_LOAD_BIT];
        t.updown = b[TCR_UPDOWN_BIT];
        t.en     = b[TCR_EN_BIT];
        t.cks    = b[TCR_CKS_MSB:TCR_CKS_LSB];
        return t;
    endfunction

endpackage

// File: rtl/apb_timer_slave_timer_counter.sv
// Prescaler, TCNT up/down counter and wrap detection for the APB timer.
// Flag set pulses are combinational and land in TSR on the same edge as the wrap.
module timer_counter
    import apb_timer_slave_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  load,
    input  logic                  updown,
    input  logic                  en,
    input  logic [1:0]            cks,
    input  logic [DATA_WIDTH-1:0] tdr,
    output logic [DATA_WIDTH-1:0] tcnt,
    output logic                  ovf_set,
    output logic                  udf_set
);

    logic [3:0] div;
    logic [3:0] tick_mask;
    logic       tick;
    logic       counting;

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        tick_mask = 4'((5'd2 << cks) - 5'd1);
        tick      = (div & tick_mask) == tick_mask;
        counting  = en & ~load;
        ovf_set   = counting & tick & ~updown & (tcnt == '1);
        udf_set   = counting & tick &  updown & (tcnt == '0);
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            div  <= '0;
            tcnt <= '0;
        end else if (load) begin
            div  <= '0;
            tcnt <= tdr;
        end else if (en) begin
            div <= div + 4'd1;
            if (tick) begin
                tcnt <= updown ? tcnt - 1'b1 : tcnt + 1'b1;
            end
        end else begin
            div <= '0;
        end
    end

endmodule

// File: rtl/apb_timer_slave.sv
// APB completer for the 8-bit timer: APB phase FSM, TDR/TCR/TSR register file,
// W1C flag handling and the read mux. Counting lives in timer_counter.
module apb_timer_slave
    import apb_timer_slave_pkg::*;
#(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 8,
    parameter int WAIT_STATES = 0
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR,
    output logic                  tmr_ovf,
    output logic                  tmr_udf
);

    apb_state_e state_q, state_d;
    logic [1:0] wait_q, wait_d;
    logic       access;
    logic       ready;

    logic [DATA_WIDTH-1:0] tdr;
    tcr_t                  tcr;
    logic                  ovf, udf;
    logic [DATA_WIDTH-1:0] tcnt;
    logic                  ovf_set, udf_set;

    logic hit_tdr, hit_tcr, hit_tsr, hit_tcnt, addr_ok;
    logic wr_en;
    logic [7:0]            tsr_byte;
    logic [DATA_WIDTH-1:0] rdata_mux;

    // state_q records the phase seen on the last edge; the access phase is
    // decoded in the cycle PENABLE is high so a zero-wait transfer takes 2 PCLK.
    always_comb begin
        state_d = APB_IDLE;
        wait_d  = '0;
        access  = PSEL & PENABLE & (state_q != APB_IDLE);
        ready   = access & (wait_q == 2'(WAIT_STATES));
        if (PSEL & ~PENABLE) begin
            state_d = APB_SETUP;
        end else if (access & ~ready) begin
            state_d = APB_ACCESS;
            wait_d  = wait_q + 2'd1;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= APB_IDLE;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        hit_tdr  = PADDR == ADDR_WIDTH'(TDR_ADDR);
        hit_tcr  = PADDR == ADDR_WIDTH'(TCR_ADDR);
        hit_tsr  = PADDR == ADDR_WIDTH'(TSR_ADDR);
        hit_tcnt = PADDR == ADDR_WIDTH'(TCNT_ADDR);
        addr_ok  = hit_tdr | hit_tcr | hit_tsr | hit_tcnt;
        wr_en    = ready & PWRITE;
    end

    // A set pulse wins over a same-cycle W1C so no wrap event is ever lost.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            tdr <= '0;
            tcr <= '0;
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            if (wr_en & hit_tdr) tdr <= PWDATA;
            if (wr_en & hit_tcr) tcr <= tcr_from_byte(PWDATA[7:0]);
            ovf <= ovf_set | (ovf & ~(wr_en & hit_tsr & PWDATA[TSR_OVF_BIT]));
            udf <= udf_set | (udf & ~(wr_en & hit_tsr & PWDATA[TSR_UDF_BIT]));
        end
    end

    timer_counter #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_counter (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .load    (tcr.load),
        .updown  (tcr.updown),
        .en      (tcr.en),
        .cks     (tcr.cks),
        .tdr     (tdr),
        .tcnt    (tcnt),
        .ovf_set (ovf_set),
        .udf_set (udf_set)
    );

    always_comb begin
        tsr_byte              = '0;
        tsr_byte[TSR_OVF_BIT] = ovf;
        tsr_byte[TSR_UDF_BIT] = udf;

        rdata_mux = '0;
        if (hit_tdr)       rdata_mux = tdr;
        else if (hit_tcr)  rdata_mux = DATA_WIDTH'(tcr_to_byte(tcr));
        else if (hit_tsr)  rdata_mux = DATA_WIDTH'(tsr_byte);
        else if (hit_tcnt) rdata_mux = tcnt;

        PREADY  = ready;
        PSLVERR = ready & (~addr_ok | (PWRITE & hit_tcnt));
        PRDATA  = (ready & ~PWRITE) ? rdata_mux : '0;
    end

    assign tmr_ovf = ovf;
    assign tmr_udf = udf;

endmodule

// File: doc/apb_timer_slave.md
# apb_timer_slave

APB completer for the single 8-bit timer: it implements the TDR/TCR/TSR/TCNT register file and the prescaled up/down counter. It is the responder that the team's APB master BFM drives, and it sits directly on the timer's APB port in the DUT. Overflow and underflow flags are latched in TSR and exported as level outputs.

## Interface
- ADDR_WIDTH, 8, PADDR width
- DATA_WIDTH, 8, PWDATA/PRDATA/register width
- WAIT_STATES, 0, extra ACCESS cycles with PREADY=0 (legal range 0..3)

Ports:
- PCLK  in  1  sole clock; all state changes on rising edge
- PRESETn  in  1  reset, asynchronous assert, active-low
- PSEL  in  1  APB select
- PENABLE  in  1  APB access phase
- PWRITE  in  1  1 = write, 0 = read
- PADDR  in  ADDR_WIDTH  register address
- PWDATA  in  DATA_WIDTH  write data
- PRDATA  out  DATA_WIDTH  read data; valid when PSEL&PENABLE&PREADY
- PREADY  out  1  transfer-complete handshake
- PSLVERR  out  1  error response; valid with PREADY
- tmr_ovf  out  1  mirrors TSR.OVF
- tmr_udf  out  1  mirrors TSR.UDF

## Operation
- Register map:
  - TDR 0x00 RW
  - TCR 0x01 RW
  - TSR 0x02 R/W1C
  - TCNT 0x03 RO
  - any other address → PSLVERR=1, read data 0, write ignored.
- TCR bits: LOAD[7], UPDOWN[5] (0 up, 1 down), EN[4], CKS[1:0]. Other bits are not stored and read 0.
- TSR bits: OVF[0], UDF[1]. Bits [7:2] read 0.
- A write to TCNT completes with PSLVERR=1 and has no effect.
- A write commits on the edge where PSEL&PENABLE&PREADY&PWRITE.
- LOAD=1: TCNT←TDR every cycle. The prescaler is held at 0, no counting occurs, and no flag is set. LOAD has priority over EN.
- EN=1, LOAD=0:
  - The 4-bit prescaler div increments every cycle.
  - tick = div[CKS:0] all ones, so the period is 2, 4, 8 or 16 PCLK for CKS 0..3.
  - On tick, TCNT±1 mod 256.
- EN=0 and LOAD=0: TCNT holds and the prescaler clears to 0.
- Flags:
  - Up count 0xFF→0x00 sets OVF.
  - Down count 0x00→0xFF sets UDF.
  - A flag stays set until written 1. Writing 0 has no effect.
  - If a set and a W1C hit the same cycle, set wins.
- Reset values: TDR=0, TCR=0, TSR=0, TCNT=0, div=0, PRDATA=0, PREADY=0, PSLVERR=0, tmr_ovf=0, tmr_udf=0.

## Timing
- APB FSM has three states: IDLE, SETUP, ACCESS.
  - IDLE→SETUP on PSEL&!PENABLE.
  - SETUP→ACCESS on PENABLE.
  - ACCESS holds PREADY=0 for WAIT_STATES cycles, then asserts PREADY=1 for exactly one cycle and returns to IDLE. If PSEL&!PENABLE arrives in that same cycle, it goes to SETUP (back-to-back transfers).
- With WAIT_STATES=0, PREADY is high in the first ACCESS cycle. Every transfer takes 2 PCLK.
- PREADY is 0 outside ACCESS. PSLVERR and PRDATA are 0 whenever PREADY=0.
- PRDATA is driven from registers and reflects register contents as of the start of the completing cycle. A TCNT read returns the pre-tick value if a tick coincides.
- A TCR write takes effect the cycle after commit:
  - First tick after EN 0→1 is 2^(CKS+1) cycles after commit.
  - A CKS change while running applies to the current div value, with no restart.
- TSR-flag-to-output latency is 0: tmr_ovf/tmr_udf are combinational copies of flop state.
- PRESETn low mid-transfer aborts it, forces the FSM to IDLE and all registers to reset values. The bus is released on the next PSEL.

## Structure
- Address and TCR/TSR bit-position constants come from the shared register-definition header already used by the bench (TDR_ADDR, TCR_ADDR, TSR_ADDR, TCR_*_BIT, TCR_CKS_MSB/LSB). Add TCNT_ADDR and TSR_OVF_BIT/TSR_UDF_BIT there.
- Sub-module timer_counter contains prescaler, TCNT and flag-set logic.
  - Inputs: load, updown, en, cks, tdr.
  - Outputs: tcnt, ovf_set, udf_set.
- apb_timer_slave keeps the APB FSM, register file, W1C logic and read mux.

## Test plan
- Reset then read all four addresses → 0x00 each, PSLVERR=0. Read 0x07 → PRDATA=0, PSLVERR=1.
- Write TDR=0xFC, TCR LOAD=1 then TCR EN=1 UPDOWN=0 CKS=0 → TCNT counts FC, FD, FE, FF, 00 every 2 PCLK. OVF=1 and tmr_ovf=1 at the FF→00 tick.
- TDR=0x02, down, CKS=3 → TCNT steps every 16 PCLK. UDF sets at 00→FF. Writing TSR=0xFF clears both flags.
- Write TSR=0x01 in the exact cycle a wrap sets OVF → OVF remains 1.
- Pause with EN=0 at TCNT=0x10 for 100 cycles → TCNT stays 0x10. Resume → next tick 2^(CKS+1) cycles after the commit.
- WAIT_STATES=2 build: every transfer spans 4 PCLK with PREADY high only in the last cycle. Assert PRESETn low during ACCESS → PREADY=0 and all registers 0.
